// File: rtl/count_sequencer.sv
// Run/pause/clear sequencer for the slow display counter: owns the count-rate
// prescaler and steps a WIDTH-bit count up/down with wrap or one-shot stop.
module count_sequencer #(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned PERIOD   = 100000000,
    parameter int unsigned MAXCOUNT = (2**WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dir,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap,
    output logic [1:0]       state,
    output logic             running
);

    localparam int unsigned PW = $clog2(PERIOD);
    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAXCOUNT);
    localparam logic [PW-1:0]    PLAST = PW'(PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             running_q;
    logic             step_c;
    logic             term_c;

    // A step is due only when no higher-priority command claims the cycle.
    assign step_c = (state_q == S_RUN) && (presc_q == PLAST) && !clear && !load && !stop;
    assign term_c = dir ? (count_q == '0) : (count_q == MAXV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            running_q <= (state_d == S_RUN);
        end
    end

    // Next-state: commands in priority order, then the one-shot terminal step.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else if (load) begin
            if (state_q == S_DONE) state_d = S_PAUSE;
        end else if (stop) begin
            if (state_q == S_RUN) state_d = S_PAUSE;
        end else if (start && (state_q != S_RUN)) begin
            state_d = S_RUN;
        end else if (step_c && term_c && oneshot) begin
            state_d = S_DONE;
        end
    end

    // Datapath: count, prescaler and step pulses.
    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
            presc_d = '0;
        end else if (load) begin
            count_d = (load_value > MAXV) ? MAXV : load_value;
            presc_d = '0;
        end else if (stop) begin
            presc_d = presc_q;
        end else if (start && (state_q != S_RUN)) begin
            // Restarting from DONE begins a fresh sweep from the far end.
            if (state_q == S_DONE) begin
                count_d = dir ? MAXV : '0;
                presc_d = '0;
            end
        end else if (step_c) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (term_c) begin
                wrap_d = 1'b1;
                if (!oneshot) count_d = dir ? MAXV : '0;
            end else begin
                count_d = dir ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
            end
        end else if (state_q == S_RUN) begin
            presc_d = presc_q + PW'(1);
        end
    end

    assign count   = count_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign state   = state_q;
    assign running = running_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: directed scenarios then random commands, every
// cycle compared against a behavioural model of the counter.
module tb_count_sequencer;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned PERIOD   = 4;
    localparam int unsigned MAXCOUNT = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic             dir = 1'b0, oneshot = 1'b0;
    logic [WIDTH-1:0] count;
    logic             tick, wrap, running;
    logic [1:0]       state;

    int n_asserts = 0;
    int n_fail    = 0;

    // Model state: plain integers, prescaler tracked as a phase counter.
    int  m_state = 0, m_count = 0, m_phase = 0;
    int  m_tick = 0, m_wrap = 0;

    count_sequencer #(.WIDTH(WIDTH), .PERIOD(PERIOD), .MAXCOUNT(MAXCOUNT)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .load(load), .load_value(load_value), .dir(dir), .oneshot(oneshot),
        .count(count), .tick(tick), .wrap(wrap), .state(state), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Predict the state after the coming edge from the rules of each command.
    task automatic model_edge();
        int span, nxt, crossed;
        span   = MAXCOUNT + 1;
        m_tick = 0;
        m_wrap = 0;
        if (rst) begin
            m_state = 0; m_count = 0; m_phase = 0;
        end else if (clear) begin
            m_state = 0; m_count = 0; m_phase = 0;
        end else if (load) begin
            m_count = (int'(load_value) > MAXCOUNT) ? MAXCOUNT : int'(load_value);
            m_phase = 0;
            if (m_state == 3) m_state = 2;
        end else if (stop) begin
            if (m_state == 1) m_state = 2;
        end else if (start && m_state != 1) begin
            if (m_state == 3) begin
                m_count = dir ? MAXCOUNT : 0;
                m_phase = 0;
            end
            m_state = 1;
        end else if (m_state == 1) begin
            m_phase = (m_phase + 1) % PERIOD;
            if (m_phase == 0) begin
                nxt     = (m_count + (dir ? MAXCOUNT : 1)) % span;
                crossed = dir ? (nxt > m_count) : (nxt < m_count);
                m_tick  = 1;
                m_wrap  = crossed;
                if (crossed && oneshot) m_state = 3;
                else m_count = nxt;
            end
        end
    endtask

    task automatic cyc(input logic st, input logic sp, input logic cl, input logic ld,
                       input logic [WIDTH-1:0] lv);
        start = st; stop = sp; clear = cl; load = ld; load_value = lv;
        model_edge();
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(m_count));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("state", 32'(state), 32'(m_state));
        chk("running", 32'(running), 32'(m_state == 1));
        start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        // 1: reset, start, first step latency
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        chk("t1_reset_count", 32'(count), 0);
        chk("t1_reset_state", 32'(state), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("t1_run_state", 32'(state), 1);
        idle(3);
        chk("t1_no_early_tick", 32'(tick), 0);
        idle(1);
        chk("t1_first_step", 32'(count), 1);
        chk("t1_first_tick", 32'(tick), 1);
        idle(4);
        chk("t1_second_step", 32'(count), 2);

        // 2: wrap up, then wrap down
        idle(28);
        chk("t2_at_max", 32'(count), 9);
        idle(4);
        chk("t2_wrap_up_count", 32'(count), 0);
        chk("t2_wrap_up_flag", 32'(wrap), 1);
        dir = 1'b1;
        idle(4);
        chk("t2_wrap_dn_count", 32'(count), 9);
        chk("t2_wrap_dn_flag", 32'(wrap), 1);

        // 3: pause preserves prescaler phase
        idle(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(10);
        chk("t3_frozen", 32'(count), 9);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(1);
        chk("t3_no_tick_yet", 32'(tick), 0);
        idle(1);
        chk("t3_resume_tick", 32'(tick), 1);
        chk("t3_resume_count", 32'(count), 8);

        // 4: saturating load while running
        dir = 1'b0;
        idle(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        chk("t4_load_sat", 32'(count), 9);
        idle(3);
        chk("t4_no_tick", 32'(tick), 0);
        idle(1);
        chk("t4_wrap_count", 32'(count), 0);
        chk("t4_wrap_flag", 32'(wrap), 1);

        // 5: one-shot stops at terminal
        oneshot = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
        idle(4);
        chk("t5_to_max", 32'(count), 9);
        chk("t5_to_max_wrap", 32'(wrap), 0);
        idle(4);
        chk("t5_hold_count", 32'(count), 9);
        chk("t5_done_tick", 32'(tick), 1);
        chk("t5_done_wrap", 32'(wrap), 1);
        chk("t5_done_state", 32'(state), 3);
        idle(1);
        chk("t5_done_quiet", 32'(tick), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("t5_restart_count", 32'(count), 0);
        chk("t5_restart_state", 32'(state), 1);

        // 6: clear beats load/stop and a due step; reset mid-run
        oneshot = 1'b0;
        idle(3);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
        chk("t6_clear_state", 32'(state), 0);
        chk("t6_clear_count", 32'(count), 0);
        chk("t6_clear_tick", 32'(tick), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(6);
        rst = 1'b1;
        idle(1);
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_state", 32'(state), 0);
        chk("t6_rst_running", 32'(running), 0);
        rst = 1'b0;

        // Random commands against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 23) == 0) oneshot = ~oneshot;
            rst = ($urandom_range(0, 199) == 0);
            cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 49) == 0), ($urandom_range(0, 24) == 0),
                WIDTH'($urandom_range(0, 15)));
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
